// File: rtl/impulse_stim_gen.sv
// Frame-oriented AXI-Stream test pattern source: impulse, ramp, DC or zero frames.
// Define IMPULSE_STIM_GEN_PHASE_SWEEP_EN to advance the impulse position by one sample per frame.
module impulse_stim_gen #(
    parameter int FFT_LEN      = 64,
    parameter int SAMP_PER_CLK = 4,
    parameter int WIDTH        = 16,
    parameter int FCNT_W       = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic [1:0]                          mode,
    input  logic [$clog2(FFT_LEN)-1:0]          impulse_pha,
    input  logic [WIDTH-1:0]                    impulse_val,
    input  logic [FCNT_W-1:0]                   num_frames,
    output logic [2*WIDTH*SAMP_PER_CLK-1:0]     m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [FCNT_W-1:0]                   m_axis_tuser,
    output logic                                busy,
    output logic                                done
);

    localparam int PHA_W  = $clog2(FFT_LEN);
    localparam int BEATS  = FFT_LEN / SAMP_PER_CLK;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] MODE_IMPULSE = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_DC      = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   start;

    logic [BEAT_W-1:0] beat_cnt;
    logic [FCNT_W-1:0] frame_cnt;
    logic [FCNT_W-1:0] frame_inc;

    logic [1:0]        cfg_mode;
    logic [PHA_W-1:0]  cfg_pha;
    logic [WIDTH-1:0]  cfg_val;
    logic [FCNT_W-1:0] cfg_frames;

    logic running;
    logic handshake;
    logic last_beat;
    logic [PHA_W-1:0] phase;
    logic [2*WIDTH*SAMP_PER_CLK-1:0] beat_data;

    assign running   = (state == RUN);
    assign handshake = running & m_axis_tready;
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    assign frame_inc = frame_cnt + 1'b1;

`ifdef IMPULSE_STIM_GEN_PHASE_SWEEP_EN
    assign phase = cfg_pha + PHA_W'(frame_cnt);
`else
    assign phase = cfg_pha;
`endif

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN: begin
                // Only a frame boundary can end a run, so frames are never truncated.
                if (handshake && last_beat) begin
                    if ((cfg_frames != '0) && (frame_inc == cfg_frames)) begin
                        state_next = DONE;
                    end else if (!en) begin
                        state_next = IDLE;
                    end
                end
            end
            DONE: begin
                if (!en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (start) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (handshake) begin
            if (last_beat) begin
                beat_cnt  <= '0;
                frame_cnt <= frame_inc;
            end else begin
                beat_cnt  <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode   <= '0;
            cfg_pha    <= '0;
            cfg_val    <= '0;
            cfg_frames <= '0;
        end else if (start) begin
            cfg_mode   <= mode;
            cfg_pha    <= impulse_pha;
            cfg_val    <= impulse_val;
            cfg_frames <= num_frames;
        end
    end

    for (genvar j = 0; j < SAMP_PER_CLK; j++) begin : g_samp
        logic [PHA_W-1:0] k;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;

        assign k = PHA_W'(int'(beat_cnt) * SAMP_PER_CLK + j);

        always_comb begin
            re = '0;
            im = '0;
            case (cfg_mode)
                MODE_IMPULSE: begin
                    if (k == phase) begin
                        re = cfg_val;
                    end
                end
                MODE_RAMP: begin
                    re = WIDTH'(k);
                    im = WIDTH'(frame_cnt);
                end
                MODE_DC: re = cfg_val;
                default: ;
            endcase
        end

        assign beat_data[2*WIDTH*j +: 2*WIDTH] = {im, re};
    end

    // Everything visible downstream is gated by RUN so idle and reset show clean zeros.
    assign m_axis_tvalid = running;
    assign m_axis_tlast  = running & last_beat;
    assign m_axis_tdata  = running ? beat_data : '0;
    assign m_axis_tuser  = running ? frame_cnt : '0;
    assign busy          = running;
    assign done          = (state == DONE);

endmodule

// File: tb/tb_impulse_stim_gen.sv
// Scoreboard bench for impulse_stim_gen at FFT_LEN=16, SAMP_PER_CLK=4, WIDTH=16.
// Expected beats are queued when a run is requested and compared as the DUT presents them.
module tb_impulse_stim_gen;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [3:0]   impulse_pha;
    logic [15:0]  impulse_val;
    logic [15:0]  num_frames;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [15:0]  tuser;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [15:0]  user;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    impulse_stim_gen #(
        .FFT_LEN(16),
        .SAMP_PER_CLK(4),
        .WIDTH(16),
        .FCNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .impulse_pha(impulse_pha),
        .impulse_val(impulse_val),
        .num_frames(num_frames),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast(tlast),
        .m_axis_tuser(tuser),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_beat(input logic [1:0] md, input logic [3:0] pha,
                                              input logic [15:0] val, input logic [15:0] frame,
                                              input int beat);
        logic [127:0] d;
        logic [3:0]   ph;
        logic [15:0]  re;
        logic [15:0]  im;
        int           k;
        d = '0;
`ifdef IMPULSE_STIM_GEN_PHASE_SWEEP_EN
        ph = 4'((int'(pha) + int'(frame)) % 16);
`else
        ph = pha;
`endif
        for (int j = 0; j < 4; j++) begin
            k  = beat * 4 + j;
            re = 16'h0;
            im = 16'h0;
            case (md)
                2'd0: re = (k == int'(ph)) ? val : 16'h0;
                2'd1: begin re = 16'(k); im = frame; end
                2'd2: re = val;
                default: ;
            endcase
            d[32*j +: 32] = {im, re};
        end
        return d;
    endfunction

    // Monitor: compare every presented beat with the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && tvalid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", 128'(tvalid), 128'd0);
            end else begin
                checkOutput("tdata", tdata, sb[0].data);
                checkOutput("tlast", 128'(tlast), 128'(sb[0].last));
                checkOutput("tuser", 128'(tuser), 128'(sb[0].user));
                if (tready) begin
                    void'(sb.pop_front());
                    hs_count++;
                end
            end
        end
    end

    // Queue the expected beats, raise en, then scramble inputs to prove config is latched.
    task automatic applyStimulus(input logic [1:0] md, input logic [3:0] pha, input logic [15:0] val,
                                 input logic [15:0] nf, input int push_frames);
        beat_t b;
        for (int f = 0; f < push_frames; f++) begin
            for (int bt = 0; bt < 4; bt++) begin
                b.data = exp_beat(md, pha, val, 16'(f), bt);
                b.last = (bt == 3);
                b.user = 16'(f);
                sb.push_back(b);
            end
        end
        mode        = md;
        impulse_pha = pha;
        impulse_val = val;
        num_frames  = nf;
        en          = 1'b1;
        @(posedge clk);
        #1;
        mode        = ~md;
        impulse_pha = ~pha;
        impulse_val = ~val;
        num_frames  = nf ^ 16'h0005;
    endtask

    task automatic wait_drain(input bit toggle, input int budget);
        int cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            @(posedge clk);
            #1;
            if (toggle) tready = ~tready;
            cyc++;
        end
        checkOutput("drain_timeout", 128'(sb.size()), 128'd0);
        tready = 1'b1;
    endtask

    task automatic wait_handshakes(input int target, input int budget);
        int cyc = 0;
        while (hs_count < target && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("hs_timeout", 128'(hs_count >= target), 128'd1);
    endtask

    task automatic finish_run(input logic exp_done);
        checkOutput("done_flag", 128'(done), 128'(exp_done));
        checkOutput("busy_after", 128'(busy), 128'd0);
        checkOutput("tvalid_after", 128'(tvalid), 128'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_done", 128'(done), 128'd0);
        checkOutput("idle_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        int base;
        rst_n       = 1'b1;
        en          = 1'b0;
        mode        = 2'd0;
        impulse_pha = 4'd0;
        impulse_val = 16'd0;
        num_frames  = 16'd0;
        tready      = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_tvalid", 128'(tvalid), 128'd0);
        checkOutput("rst_tlast", 128'(tlast), 128'd0);
        checkOutput("rst_tdata", tdata, 128'd0);
        checkOutput("rst_tuser", 128'(tuser), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_done", 128'(done), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] impulse pha=5 val=7, two frames");
        base = hs_count;
        applyStimulus(2'd0, 4'd5, 16'd7, 16'd2, 2);
        wait_drain(1'b0, 40);
        checkOutput("impulse_hs", 128'(hs_count - base), 128'd8);
        @(posedge clk);
        #1;
        checkOutput("done_hold", 128'(done), 128'd1);
        finish_run(1'b1);

        $display("[TB] ramp, one frame, tready toggling");
        base = hs_count;
        tready = 1'b1;
        applyStimulus(2'd1, 4'd0, 16'd0, 16'd1, 1);
        wait_drain(1'b1, 40);
        checkOutput("ramp_hs", 128'(hs_count - base), 128'd4);
        finish_run(1'b1);

        $display("[TB] continuous run, en dropped at frame 3 beat 1");
        base = hs_count;
        applyStimulus(2'd0, 4'd2, 16'd100, 16'd0, 4);
        wait_handshakes(base + 13, 60);
        en = 1'b0;
        wait_drain(1'b0, 20);
        checkOutput("cont_hs", 128'(hs_count - base), 128'd16);
        repeat (2) @(posedge clk);
        #1;
        finish_run(1'b0);

        $display("[TB] reset mid-frame");
        base = hs_count;
        applyStimulus(2'd1, 4'd0, 16'd0, 16'd0, 3);
        wait_handshakes(base + 6, 40);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        checkOutput("midrst_tvalid", 128'(tvalid), 128'd0);
        checkOutput("midrst_tdata", tdata, 128'd0);
        checkOutput("midrst_tuser", 128'(tuser), 128'd0);
        checkOutput("midrst_busy", 128'(busy), 128'd0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = hs_count;
        applyStimulus(2'd1, 4'd0, 16'd0, 16'd1, 1);
        wait_drain(1'b0, 20);
        checkOutput("restart_hs", 128'(hs_count - base), 128'd4);
        finish_run(1'b1);

        $display("[TB] impulse pha=15, three frames");
        applyStimulus(2'd0, 4'd15, 16'd9, 16'd3, 3);
        wait_drain(1'b0, 40);
        finish_run(1'b1);

        $display("[TB] DC val=-3, one frame");
        applyStimulus(2'd2, 4'd0, 16'hFFFD, 16'd1, 1);
        wait_drain(1'b0, 20);
        finish_run(1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
